// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared widths, iop field layout and step-vector encoding
//               for the decode -> schedule -> execute path.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int c_IOP_W  = 32;
    localparam int c_STEP_W = 3;

    // Field positions inside an iop
    localparam int c_IOP_AGU_MSB = 30;
    localparam int c_IOP_AGU_LSB = 24;
    localparam int c_IOP_ALU_MSB = 23;
    localparam int c_IOP_ALU_LSB = 5;
    localparam int c_IOP_MEM_MSB = 4;
    localparam int c_IOP_MEM_LSB = 3;

    // Step-vector bit meanings
    localparam int c_STEP_VALID_BIT  = 2;
    localparam int c_STEP_DIRECT_BIT = 1;
    localparam int c_STEP_AGU_BIT    = 0;

    typedef struct packed {
        logic        spare;
        logic [6:0]  agu;
        logic [18:0] alu;
        logic [1:0]  mem;
        logic [2:0]  rsvd;
    } iop_fields_t;

    typedef struct packed {
        logic valid;
        logic direct;
        logic agu;
    } step_t;

    // An all-zero remaining step vector means the iop is finished
    function automatic logic step_done(input logic [c_STEP_W-1:0] step);
        return (step == '0);
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/sched_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : sched_queue_if
// Description : Decode-side push, execute-side head/ack and status signals
//               of the scheduling queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface sched_queue_if
    import core_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int IOP_W  = c_IOP_W,
    parameter int STEP_W = c_STEP_W
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               id_feed;
    logic [IOP_W-1:0]   id_iop;
    logic [STEP_W-1:0]  id_iop_init;
    logic               flush;
    logic               hold;
    logic               sq_valid;
    logic [IOP_W-1:0]   sq_iop;
    logic [STEP_W-1:0]  sq_step;
    logic               ex_ack;
    logic [STEP_W-1:0]  ex_next_step;
    logic [c_CNT_W-1:0] sq_count;
    logic               sq_ovf;

    modport master (
        output id_feed, id_iop, id_iop_init, flush, ex_ack, ex_next_step,
        input  hold, sq_valid, sq_iop, sq_step, sq_count, sq_ovf
    );

    modport slave (
        input  id_feed, id_iop, id_iop_init, flush, ex_ack, ex_next_step,
        output hold, sq_valid, sq_iop, sq_step, sq_count, sq_ovf
    );

endinterface : sched_queue_if
`default_nettype wire

// File: rtl/sq_store.sv
`default_nettype none
// ============================================================================
// Module      : sq_store
// Description : Entry storage for the scheduling queue: one write port, one
//               step-field update port and an asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sq_store
    import core_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int IOP_W   = c_IOP_W,
    parameter  int STEP_W  = c_STEP_W,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_ENT_W = IOP_W + STEP_W
) (
    input  wire logic               clk,
    input  wire logic               wr_en,
    input  wire logic [c_PTR_W-1:0] wr_addr,
    input  wire logic [c_ENT_W-1:0] wr_data,
    input  wire logic               upd_en,
    input  wire logic [c_PTR_W-1:0] upd_addr,
    input  wire logic [STEP_W-1:0]  upd_step,
    input  wire logic [c_PTR_W-1:0] rd_addr,
    output logic      [c_ENT_W-1:0] rd_data
);

    logic [DEPTH-1:0][c_ENT_W-1:0] w_rows;

    // Contents need no reset: the queue never presents an entry it has not written.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [c_ENT_W-1:0] r_row;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == c_PTR_W'(i))) begin
                r_row <= wr_data;
            end else if (upd_en && (upd_addr == c_PTR_W'(i))) begin
                r_row <= {r_row[c_ENT_W-1:STEP_W], upd_step};
            end
        end

        assign w_rows[i] = r_row;
    end

    assign rd_data = w_rows[rd_addr];

endmodule : sq_store
`default_nettype wire

// File: rtl/sched_queue.sv
`default_nettype none
// ============================================================================
// Module      : sched_queue
// Description : In-order scheduling queue between decode and execute; retires
//               the head once its step vector reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_queue
    import core_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int IOP_W  = c_IOP_W,
    parameter int STEP_W = c_STEP_W
) (
    input wire logic    clk,
    input wire logic    a_rst,
    sched_queue_if.slave sq
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam int                 c_ENT_W = IOP_W + STEP_W;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;

    logic               w_hold;
    logic               w_valid;
    logic               w_push;
    logic               w_ack;
    logic               w_pop;
    logic               w_upd;
    logic [c_ENT_W-1:0] w_head;

    // hold must come from registered state only so decode never sees a loop
    assign w_hold  = (r_count == c_FULL);
    assign w_valid = (r_count != '0);

    assign w_push = sq.id_feed & ~w_hold & ~sq.flush;
    assign w_ack  = sq.ex_ack & w_valid & ~sq.flush;
    assign w_pop  = w_ack & step_done(sq.ex_next_step);
    assign w_upd  = w_ack & ~w_pop;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (sq.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow is sticky and independent of flush
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_ovf <= 1'b0;
        end else if (sq.id_feed && w_hold) begin
            r_ovf <= 1'b1;
        end
    end

    sq_store #(
        .DEPTH  (DEPTH),
        .IOP_W  (IOP_W),
        .STEP_W (STEP_W)
    ) u_store (
        .clk      (clk),
        .wr_en    (w_push),
        .wr_addr  (r_wr_ptr),
        .wr_data  ({sq.id_iop, sq.id_iop_init}),
        .upd_en   (w_upd),
        .upd_addr (r_rd_ptr),
        .upd_step (sq.ex_next_step),
        .rd_addr  (r_rd_ptr),
        .rd_data  (w_head)
    );

    assign sq.hold     = w_hold;
    assign sq.sq_valid = w_valid;
    assign sq.sq_iop   = w_valid ? w_head[c_ENT_W-1:STEP_W] : '0;
    assign sq.sq_step  = w_valid ? w_head[STEP_W-1:0]       : '0;
    assign sq.sq_count = r_count;
    assign sq.sq_ovf   = r_ovf;

endmodule : sched_queue
`default_nettype wire
